// File: rtl/pudc.sv
// pudc: parametrised up/down modulo counter for one seven-segment display digit.
//
// Counts over 0..MODULUS-1 in either direction, stepping once every DIV enabled
// clocks. A synchronous load (clamped to MODULUS-1) overrides stepping. In wrap
// mode the counter rolls over and raises a combinational carry/borrow so that
// several instances can be chained into a multi-digit counter on one clock.
//
// Parameters:
//   WIDTH    bit width of the count value and load data
//   MODULUS  count range is 0..MODULUS-1, legal 2..2^WIDTH
//   DIV      prescaler ratio, counter steps once every DIV enabled clocks (>= 1)
//
// Ports:
//   pudc_clk   in   rising-edge clock
//   pudc_rst   in   asynchronous active-low reset
//   pudc_en    in   count enable, gates prescaler and counter
//   pudc_dir   in   1 = up, 0 = down
//   pudc_sat   in   1 = saturate at limits, 0 = wrap
//   pudc_load  in   synchronous load strobe
//   pudc_din   in   load value
//   pudc_q     out  registered count value
//   pudc_tick  out  prescaler strobe, high in the cycle a step will occur
//   pudc_lim   out  count is at the limit for the current direction
//   pudc_co    out  carry/borrow, high in the cycle before a wrap
module pudc #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10,
    parameter int unsigned DIV     = 1
) (
    input  logic             pudc_clk,
    input  logic             pudc_rst,
    input  logic             pudc_en,
    input  logic             pudc_dir,
    input  logic             pudc_sat,
    input  logic             pudc_load,
    input  logic [WIDTH-1:0] pudc_din,
    output logic [WIDTH-1:0] pudc_q,
    output logic             pudc_tick,
    output logic             pudc_lim,
    output logic             pudc_co
);

    localparam int unsigned      PcW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] QMax  = WIDTH'(MODULUS - 1);
    localparam logic [PcW-1:0]   PcMax = PcW'(DIV - 1);
    // With MODULUS == 2^WIDTH every code is in range, so no range checks are built.
    localparam bit               Full  = (64'(MODULUS) == (64'd1 << WIDTH));

    logic [WIDTH-1:0] q_q, q_d;
    logic [PcW-1:0]   pc_q, pc_d;
    logic             tick;
    logic             lim;
    logic             q_oor;
    logic [WIDTH-1:0] din_clamped;

    generate
        if (Full) begin : g_full
            assign q_oor       = 1'b0;
            assign din_clamped = pudc_din;
        end else begin : g_part
            assign q_oor       = (q_q > QMax);
            assign din_clamped = (pudc_din > QMax) ? QMax : pudc_din;
        end
    endgenerate

    // Tick is gated by reset so the strobe is quiet while the block is held in reset.
    assign tick = pudc_rst & pudc_en & (pc_q == PcMax);
    assign lim  = pudc_dir ? (q_q == QMax) : (q_q == '0);

    assign pudc_q    = q_q;
    assign pudc_tick = tick;
    assign pudc_lim  = lim;
    // A load in the same cycle suppresses the step, so no wrap happens either.
    assign pudc_co   = tick & lim & ~pudc_sat & ~pudc_load;

    always_comb begin
        pc_d = pc_q;
        if (pudc_load) begin
            pc_d = '0;
        end else if (pudc_en) begin
            pc_d = (pc_q == PcMax) ? '0 : pc_q + PcW'(1);
        end
    end

    always_comb begin
        q_d = q_q;
        if (pudc_load) begin
            q_d = din_clamped;
        end else if (tick) begin
            if (pudc_dir) begin
                if (q_oor) begin
                    q_d = '0;
                end else if (lim) begin
                    q_d = pudc_sat ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_oor) begin
                    q_d = QMax;
                end else if (lim) begin
                    q_d = pudc_sat ? q_q : QMax;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge pudc_clk or negedge pudc_rst) begin
        if (!pudc_rst) begin
            q_q  <= '0;
            pc_q <= '0;
        end else begin
            q_q  <= q_d;
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pudc.sv
// tb_pudc: self-checking bench for pudc.
//
// Four instances share one clock:
//   0: WIDTH=4 MODULUS=10 DIV=3 (prescaler)
//   1: WIDTH=4 MODULUS=10 DIV=1 (units digit)
//   2: WIDTH=4 MODULUS=10 DIV=1 (tens digit, enabled by the units carry)
//   3: WIDTH=3 MODULUS=8  DIV=2 (full-range modulus)
// A behavioural model predicts every output each cycle; directed phases follow
// the intended use cases, then a randomized phase runs against the same model.
module tb_pudc;

    logic       clk = 1'b0;
    logic       rst;
    logic       dir;
    logic       sat;
    logic [3:0] en_r;
    logic [3:0] ld_r;
    logic [3:0] din_r [3];
    logic [2:0] din3;

    logic [3:0] q0, q1, q2;
    logic [2:0] q3;
    logic [3:0] tick_w, lim_w, co_w;

    int n_chk  = 0;
    int n_fail = 0;

    int mq  [4];
    int mpc [4];
    int MODV [4] = '{10, 10, 10, 8};
    int DVV  [4] = '{3, 1, 1, 2};

    always #5 clk = ~clk;

    pudc #(.WIDTH(4), .MODULUS(10), .DIV(3)) u_a (
        .pudc_clk(clk), .pudc_rst(rst), .pudc_en(en_r[0]), .pudc_dir(dir),
        .pudc_sat(sat), .pudc_load(ld_r[0]), .pudc_din(din_r[0]), .pudc_q(q0),
        .pudc_tick(tick_w[0]), .pudc_lim(lim_w[0]), .pudc_co(co_w[0])
    );

    pudc #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_units (
        .pudc_clk(clk), .pudc_rst(rst), .pudc_en(en_r[1]), .pudc_dir(dir),
        .pudc_sat(sat), .pudc_load(ld_r[1]), .pudc_din(din_r[1]), .pudc_q(q1),
        .pudc_tick(tick_w[1]), .pudc_lim(lim_w[1]), .pudc_co(co_w[1])
    );

    pudc #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_tens (
        .pudc_clk(clk), .pudc_rst(rst), .pudc_en(co_w[1] & en_r[2]), .pudc_dir(dir),
        .pudc_sat(sat), .pudc_load(ld_r[2]), .pudc_din(din_r[2]), .pudc_q(q2),
        .pudc_tick(tick_w[2]), .pudc_lim(lim_w[2]), .pudc_co(co_w[2])
    );

    pudc #(.WIDTH(3), .MODULUS(8), .DIV(2)) u_d (
        .pudc_clk(clk), .pudc_rst(rst), .pudc_en(en_r[3]), .pudc_dir(dir),
        .pudc_sat(sat), .pudc_load(ld_r[3]), .pudc_din(din3), .pudc_q(q3),
        .pudc_tick(tick_w[3]), .pudc_lim(lim_w[3]), .pudc_co(co_w[3])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_din(int i);
        return (i == 3) ? int'(din3) : int'(din_r[i]);
    endfunction

    function automatic bit m_tick_en(int i, bit e);
        return rst && e && (mpc[i] == DVV[i] - 1);
    endfunction

    function automatic bit m_lim(int i);
        return dir ? (mq[i] == MODV[i] - 1) : (mq[i] == 0);
    endfunction

    function automatic bit m_co_of(int i, bit e);
        return m_tick_en(i, e) && m_lim(i) && !sat && !ld_r[i];
    endfunction

    function automatic bit m_en(int i);
        if (i == 2) return en_r[2] && m_co_of(1, en_r[1]);
        return en_r[i];
    endfunction

    function automatic int dut_q(int i);
        case (i)
            0: return int'(q0);
            1: return int'(q1);
            2: return int'(q2);
            default: return int'(q3);
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i]  = 0;
            mpc[i] = 0;
        end
    endtask

    task automatic m_edge();
        int nq [4];
        int npc [4];
        for (int i = 0; i < 4; i++) begin
            bit e;
            bit t;
            e = m_en(i);
            t = m_tick_en(i, e);
            if (!rst) begin
                nq[i]  = 0;
                npc[i] = 0;
            end else if (ld_r[i]) begin
                nq[i]  = (m_din(i) > MODV[i] - 1) ? MODV[i] - 1 : m_din(i);
                npc[i] = 0;
            end else begin
                npc[i] = e ? (mpc[i] + 1) % DVV[i] : mpc[i];
                nq[i]  = mq[i];
                if (t) begin
                    if (dir)
                        nq[i] = sat ? ((mq[i] + 1 > MODV[i] - 1) ? MODV[i] - 1 : mq[i] + 1)
                                    : (mq[i] + 1) % MODV[i];
                    else
                        nq[i] = sat ? ((mq[i] - 1 < 0) ? 0 : mq[i] - 1)
                                    : (mq[i] + MODV[i] - 1) % MODV[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            mq[i]  = nq[i];
            mpc[i] = npc[i];
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            bit e;
            e = m_en(i);
            check($sformatf("q[%0d]", i), dut_q(i), mq[i]);
            check($sformatf("tick[%0d]", i), int'(tick_w[i]), int'(m_tick_en(i, e)));
            check($sformatf("lim[%0d]", i), int'(lim_w[i]), int'(m_lim(i)));
            check($sformatf("co[%0d]", i), int'(co_w[i]), int'(m_co_of(i, e)));
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic async_reset_pulse();
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        check("rst_q_units", int'(q1), 0);
        check("rst_q_tens", int'(q2), 0);
        check("rst_tick_units", int'(tick_w[1]), 0);
        compare_all();
        @(posedge clk);
        m_edge();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        dir  = 1'b1;
        sat  = 1'b0;
        en_r = '0;
        ld_r = '0;
        for (int i = 0; i < 3; i++) din_r[i] = '0;
        din3 = '0;
        m_reset();

        // Reset and prescaler
        repeat (2) cyc();
        rst     = 1'b1;
        en_r[0] = 1'b1;
        en_r[3] = 1'b1;
        repeat (3) cyc();
        check("a_q_after3", int'(q0), 1);
        repeat (3) cyc();
        check("a_q_after6", int'(q0), 2);

        // Up wrap on the units digit
        ld_r[1] = 1'b1; din_r[1] = 4'd8;
        cyc();
        ld_r[1] = 1'b0;
        check("u_load8", int'(q1), 8);
        en_r[1] = 1'b1;
        cyc();
        check("u_co_at9", int'(co_w[1]), 1);
        check("u_lim_at9", int'(lim_w[1]), 1);
        repeat (2) cyc();
        check("u_wrap_up", int'(q1), 1);

        // Down wrap, then direction change
        dir = 1'b0;
        cyc();
        check("u_co_at0", int'(co_w[1]), 1);
        repeat (2) cyc();
        check("u_wrap_down", int'(q1), 8);
        dir = 1'b1;
        repeat (2) cyc();
        check("u_dir_change", int'(q1), 0);

        // Saturate
        sat = 1'b1;
        ld_r[1] = 1'b1; din_r[1] = 4'd7;
        cyc();
        ld_r[1] = 1'b0;
        repeat (5) cyc();
        check("u_sat_up", int'(q1), 9);
        check("u_sat_co", int'(co_w[1]), 0);
        ld_r[1] = 1'b1; din_r[1] = 4'd1;
        cyc();
        ld_r[1] = 1'b0;
        dir = 1'b0;
        repeat (2) cyc();
        check("u_sat_down", int'(q1), 0);
        check("u_sat_lim", int'(lim_w[1]), 1);
        sat = 1'b0;

        // Load clamp with enable low
        en_r[1] = 1'b0;
        ld_r[1] = 1'b1; din_r[1] = 4'd12;
        cyc();
        ld_r[1] = 1'b0;
        check("u_clamp", int'(q1), 9);

        // Load during tick restarts the prescaler
        dir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (m_tick_en(0, en_r[0])) break;
            cyc();
        end
        check("a_tick_before_load", int'(tick_w[0]), 1);
        ld_r[0] = 1'b1; din_r[0] = 4'd3;
        check("a_co_forced_low", int'(co_w[0]), 0);
        cyc();
        ld_r[0] = 1'b0;
        check("a_load3", int'(q0), 3);
        repeat (2) cyc();
        check("a_hold_after_load", int'(q0), 3);
        cyc();
        check("a_step_after_load", int'(q0), 4);

        // Cascade 0..23, then async reset mid-count
        async_reset_pulse();
        en_r[1] = 1'b1;
        en_r[2] = 1'b1;
        dir = 1'b1;
        sat = 1'b0;
        repeat (23) cyc();
        check("cascade_units", int'(q1), 3);
        check("cascade_tens", int'(q2), 2);
        async_reset_pulse();
        cyc();

        // Randomized phase against the model
        for (int n = 0; n < 600; n++) begin
            if (!rst) rst = 1'b1;
            else if ($urandom_range(79) == 0) begin
                rst = 1'b0;
                m_reset();
            end
            for (int i = 0; i < 4; i++) begin
                en_r[i] = ($urandom_range(3) != 0);
                ld_r[i] = ($urandom_range(9) == 0);
            end
            for (int i = 0; i < 3; i++) din_r[i] = 4'($urandom_range(15));
            din3 = 3'($urandom_range(7));
            if ($urandom_range(7) == 0) dir = ~dir;
            if ($urandom_range(15) == 0) sat = ~sat;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
